// File: rtl/nibble_add_seq.sv
// Multi-nibble add sequencer: streams W-bit operands through an external 4-bit adder,
// least significant nibble first, with the carry chained through a register.
//
// state | meaning
// IDLE  | waiting for an operand pair
// RUN   | one nibble per clock through add4
// DONE  | result held until the consumer takes it
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_ci,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_ci,
    input  logic [3:0]           add_sum,
    input  logic                 add_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_co,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_reg, b_reg, result;
    logic            carry_reg;
    logic [IW-1:0]   idx;
    logic [IW+1:0]   base;
    logic            accept;
    logic            last;

    assign base   = {idx, 2'b00};
    assign last   = (idx == LAST);
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Adder inputs come only from registers so the ripple path starts at a flop.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_ci    = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy   = 1'b1;
                add_a  = a_reg[base +: 4];
                add_b  = b_reg[base +: 4];
                add_ci = carry_reg;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_ci;
            idx       <= '0;
        end else if (state == RUN) begin
            result[base +: 4] <= add_sum;
            carry_reg         <= add_co;
            if (last) begin
                out_co  <= add_co;
                out_ovf <= (a_reg[W-1] == b_reg[W-1]) & (add_sum[3] != a_reg[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum = result;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq with a behavioural add4 and a whole-word reference model.
module tb_nibble_add_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_ci;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_ci, add_co;
    logic         out_valid, out_ready;
    logic [W-1:0] out_sum;
    logic         out_co, out_ovf, busy;

    int tests = 0;
    int fails = 0;

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_sum(add_sum), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_co(out_co), .out_ovf(out_ovf),
        .busy(busy)
    );

    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] s;
        s = ref_sum(a, b, ci);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Called one tick after the accept edge; returns one tick after the edge that enters DONE.
    task automatic do_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [63:0] mask, cin;
        logic [W:0]  s;
        for (int k = 0; k < N; k++) begin
            mask = (64'd1 << (4 * k)) - 64'd1;
            cin  = (((64'(a) & mask) + (64'(b) & mask) + 64'(ci)) >> (4 * k)) & 64'd1;
            chk("add_a", add_a, (64'(a) >> (4 * k)) & 64'hF);
            chk("add_b", add_b, (64'(b) >> (4 * k)) & 64'hF);
            chk("add_ci", add_ci, cin);
            chk("busy_run", busy, 1);
            chk("in_ready_run", in_ready, 0);
            chk("out_valid_run", out_valid, 0);
            step();
        end
        s = ref_sum(a, b, ci);
        chk("out_valid_done", out_valid, 1);
        chk("busy_done", busy, 0);
        chk("out_sum", out_sum, s[W-1:0]);
        chk("out_co", out_co, s[W]);
        chk("out_ovf", out_ovf, ref_ovf(a, b, ci));
        chk("add_a_done", add_a, 0);
    endtask

    task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold);
        logic [W:0] s;
        s         = ref_sum(a, b, ci);
        chk("in_ready_idle", in_ready, 1);
        in_a      = a;
        in_b      = b;
        in_ci     = ci;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid  = 1'b0;
        do_run(a, b, ci);
        for (int j = 0; j < hold; j++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, s[W-1:0]);
        end
        out_ready = 1'b1;
        step();
        chk("back_idle_valid", out_valid, 0);
        chk("back_idle_ready", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_out_co"}, out_co, 0);
        chk({tag, "_out_ovf"}, out_ovf, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_add"}, {add_a, add_b, add_ci}, 0);
    endtask

    logic [W-1:0] ra, rb, ba[3], bb[3];
    logic         rc, bc[3];
    logic [W:0]   s;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        out_ready = 1'b1;
        step();
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;

        // Directed cases
        single_op(16'h1234, 16'h0FFF, 1'b0, 0);
        single_op(16'hFFFF, 16'h0001, 1'b0, 0);
        single_op(16'h7FFF, 16'h0000, 1'b1, 0);
        single_op(16'h8000, 16'h8000, 1'b0, 0);

        // Backpressure with a second operand pair waiting
        in_a = 16'hA5A5; in_b = 16'h1111; in_ci = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_a = 16'h0F0F; in_b = 16'hF0F0; in_ci = 1'b1;
        do_run(16'hA5A5, 16'h1111, 1'b1);
        s = ref_sum(16'hA5A5, 16'h1111, 1'b1);
        for (int j = 0; j < 3; j++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, s[W-1:0]);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_busy_next", busy, 1);
        in_valid = 1'b0;
        do_run(16'h0F0F, 16'hF0F0, 1'b1);
        step();
        chk("bp_idle", out_valid, 0);

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
            bc[i] = 1'($urandom);
        end
        in_a = ba[0]; in_b = bb[0]; in_ci = bc[0];
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                in_a = ba[i+1]; in_b = bb[i+1]; in_ci = bc[i+1];
            end else begin
                in_valid = 1'b0;
            end
            do_run(ba[i], bb[i], bc[i]);
            step();
        end
        chk("b2b_idle", out_valid, 0);

        // Reset in the middle of RUN
        in_a = 16'h4321; in_b = 16'h1234; in_ci = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_idx2_add_a", add_a, 4'h3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("midrst_no_valid", out_valid, 0);
            step();
        end
        single_op(16'h0001, 16'h0002, 1'b1, 0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            single_op(ra, rb, rc, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-nibble add sequencer wrapped around the 4-bit ripple adder (`add4`). It accepts a W-bit operand pair over a valid/ready handshake. It drives the adder one nibble per clock, least significant first, and chains the carry through a register. It collects the sum nibbles and presents the W-bit result, carry-out and signed overflow on an output valid/ready handshake. It sits directly upstream and downstream of `add4`: it feeds the adder's a/b/ci inputs and consumes its sum/co outputs.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  sequencer can accept operands this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_ci  in  1  initial carry-in
- add_a  out  4  nibble of A to adder
- add_b  out  4  nibble of B to adder
- add_ci  out  1  carry to adder
- add_sum  in  4  adder sum, combinational from add_a/add_b/add_ci
- add_co  in  1  adder carry-out, combinational
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_sum  out  W  result
- out_co  out  1  carry out of MSB nibble
- out_ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN

## Operation
- State machine: IDLE, RUN, DONE. Internal registers:
  - a_reg, b_reg (W bits)
  - carry_reg (1 bit)
  - idx (ceil(log2(NIBBLES)) bits, minimum 1)
  - result (W bits)
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. On accept:
  - capture a_reg, b_reg, carry_reg <= in_ci, idx <= 0
  - go to RUN, from either IDLE or DONE.
- RUN drives the adder with:
  - add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[same], add_ci = carry_reg.
- RUN, each edge:
  - result[4*idx+3:4*idx] <= add_sum, carry_reg <= add_co
  - if idx==NIBBLES-1: go to DONE, set out_co <= add_co and out_ovf <= (a_reg[W-1]==b_reg[W-1]) & (add_sum[3]!=a_reg[W-1])
  - otherwise idx <= idx+1.
- In IDLE and DONE, add_a, add_b and add_ci are 0.
- out_valid = (state==DONE). out_sum, out_co and out_ovf are registered and hold stable while out_valid & !out_ready.
- DONE & out_ready & !in_valid: go to IDLE.
- DONE & out_ready & in_valid: accept new operands and go to RUN in the same edge.
- No combinational path from in_* or out_ready to add_*. add_* come from registers only.
- Width rule: nibble arithmetic is modulo 16. Carry propagates only via carry_reg. The final sum is exact modulo 2^W, with out_co the 2^W bit.
- NIBBLES==1: RUN lasts one cycle.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, idx 0, carry_reg 0, result 0. Outputs take these values:
  - out_valid 0, out_sum 0, out_co 0, out_ovf 0
  - busy 0, in_ready 1
  - add_a 0, add_b 0, add_ci 0
- Deassertion of rst_n is synchronized externally; the first accept can occur on the first rising edge after release.
- Reset mid-RUN or mid-DONE discards the operation; out_valid is never asserted for it.
- Latency: accept on edge E. Nibble k is computed in the cycle after edge E+k and stored at edge E+k+1. out_valid is high from edge E+NIBBLES.
- Throughput: one operation per NIBBLES+1 cycles with out_ready held high.
- The clock period must exceed the add4 ripple delay (4 addbit stages) plus register setup.
- Simultaneous events:
  - in_valid while RUN: ignored, in_ready 0.
  - out_ready while not DONE: no effect.

## Test plan
- NIBBLES=4, in_a=0x1234, in_b=0x0FFF, in_ci=0, out_ready=1: out_valid rises 4 edges after accept; out_sum=0x2233, out_co=0, out_ovf=0; add_a sequence 4,3,2,1.
- in_a=0xFFFF, in_b=0x0001, in_ci=0: out_sum=0x0000, out_co=1, out_ovf=0; add_ci sequence 0,1,1,1.
- in_a=0x7FFF, in_b=0x0000, in_ci=1: out_sum=0x8000, out_co=0, out_ovf=1.
- Backpressure: out_ready low for 3 cycles in DONE, with in_valid held high: out_sum is stable, in_ready=0, no new accept. out_ready then rises: the new accept occurs in the same edge and busy=1 next cycle.
- Back-to-back: 3 operations with in_valid and out_ready continuously high: out_valid pulses every 5 cycles, each result correct.
- Reset mid-RUN: assert rst_n low at idx=2 for one cycle: all outputs return to reset values immediately; no out_valid for that operation; the next operation completes correctly.
